alu_lockstep_monitor: RTL

//  Downstream consumer of the dual 4-bit ALU lockstep pair (alu_xor_4) inside
//  the user project wrapper. Registers both ALU results and carries, flags

---
 rtl/alu_lockstep_monitor.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/alu_lockstep_monitor.sv
// Lockstep monitor for the dual 4-bit ALU pair: registers both lanes, counts
// divergences, escalates to a sticky fault and logs events in a FWFT FIFO. Optional macro: LOCKSTEP_MON_IRQ_EN.
module alu_lockstep_monitor #(
    parameter int CNT_W      = 16,
    parameter int THRESH     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int TS_W       = 8
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_n,
    input  logic                en_i,
    input  logic                clr_i,
    input  logic [3:0]          alu_out1_i,
    input  logic [3:0]          alu_out2_i,
    input  logic                carry1_i,
    input  logic                carry2_i,
    input  logic                pop_i,
    output logic                evt_valid_o,
    output logic [TS_W+9:0]     evt_data_o,
    output logic                fault_o,
    output logic [1:0]          state_o,
    output logic [CNT_W-1:0]    mis_cnt_o,
    output logic                ovf_o
`ifdef LOCKSTEP_MON_IRQ_EN
    ,
    output logic                irq_o
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = TS_W + 10;
    localparam logic [3:0] THRESH_L = 4'(THRESH);

    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, SUSPECT = 2'd2, FAULT = 2'd3} state_t;

    state_t           state_q, state_d;
    logic [3:0]       rc_q, rc_d, rc_inc;
    logic [3:0]       s1_out1_q, s1_out2_q;
    logic             s1_c1_q, s1_c2_q;
    logic [TS_W-1:0]  ts_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;
    logic [EW-1:0]    mem_q [FIFO_DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic             irq_q;

    logic mis, fifo_empty, fifo_full, push_req, do_push, do_pop, drop;

    // Pop handshake: an event is consumed on a clock edge where pop_i=1 and
    // evt_valid_o=1; pop_i with evt_valid_o=0 has no effect. Head data is
    // visible on evt_data_o whenever evt_valid_o=1 (first-word-fall-through).
    always_comb begin
        mis        = (s1_out1_q != s1_out2_q) || (s1_c1_q != s1_c2_q);
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop     = pop_i && !fifo_empty && !clr_i;
        push_req   = (state_q != IDLE) && mis && !clr_i;
        do_push    = push_req && (!fifo_full || do_pop);
        drop       = push_req && fifo_full && !do_pop;
        rc_inc     = rc_q + 4'd1;
    end

    always_comb begin
        state_d = state_q;
        rc_d    = rc_q;
        if (clr_i) begin
            state_d = en_i ? ARMED : IDLE;
            rc_d    = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    rc_d = 4'd0;
                    if (en_i) state_d = ARMED;
                end
                ARMED, SUSPECT: begin
                    if (!en_i) begin
                        state_d = IDLE;
                        rc_d    = 4'd0;
                    end else if (mis) begin
                        rc_d    = rc_inc;
                        state_d = (rc_inc >= THRESH_L) ? FAULT : SUSPECT;
                    end else begin
                        state_d = ARMED;
                        rc_d    = 4'd0;
                    end
                end
                FAULT: state_d = FAULT;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q   <= IDLE;
            rc_q      <= 4'd0;
            s1_out1_q <= 4'd0;
            s1_out2_q <= 4'd0;
            s1_c1_q   <= 1'b0;
            s1_c2_q   <= 1'b0;
            ts_q      <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            irq_q     <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            s1_out1_q <= alu_out1_i;
            s1_out2_q <= alu_out2_i;
            s1_c1_q   <= carry1_i;
            s1_c2_q   <= carry2_i;
            state_q   <= state_d;
            rc_q      <= rc_d;
            if (clr_i) begin
                ts_q     <= '0;
                cnt_q    <= '0;
                ovf_q    <= 1'b0;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                irq_q    <= 1'b0;
            end else begin
                if (en_i) ts_q <= ts_q + 1'b1;
                if (push_req && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                if (do_push) begin
                    mem_q[wr_ptr_q[AW-1:0]] <= {ts_q, s1_c2_q, s1_c1_q, s1_out2_q, s1_out1_q};
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
                if (drop) ovf_q <= 1'b1;
                if ((state_d == FAULT && state_q != FAULT) || (drop && !ovf_q)) irq_q <= 1'b1;
            end
        end
    end

    assign evt_valid_o = !fifo_empty;
    assign evt_data_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign fault_o     = (state_q == FAULT);
    assign state_o     = state_q;
    assign mis_cnt_o   = cnt_q;
    assign ovf_o       = ovf_q;

`ifdef LOCKSTEP_MON_IRQ_EN
    assign irq_o = irq_q;
`else
    logic unused_irq;
    assign unused_irq = irq_q;
`endif
endmodule
